sudoku_checker: RTL
===================

# sudoku_checker

Rule checker downstream of the game core. Watches the 81-cell board the core publishes on `cur_map` and rescans it whenever it changes, one 9-cell unit per clock: 9 rows, then 9 columns, then 9 boxes. Publishes `win_tag` (board complete and legal) and `conflict` (some digit repeats within a unit). `win_tag` feeds straight back into the game core's `win_tag` input.

## Interface
- No parameters; geometry is fixed at 9x9, 4-bit cells.
- `CLK_100MHz`  in  1  system clock, all state on the rising edge
- `RST_n`  in  1  asynchronous, active-low reset
- `init_tag`  in  1  board valid/enabled; low forces idle and clears results
- `cur_map`  in  324  board; cell i = row*9+col occupies `cur_map[4i+3:4i]`
- `win_tag`  out  1  last completed scan: all 81 cells hold 1..9 and no duplicates
- `conflict`  out  1  last completed scan found a duplicate in some unit
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse when results update
- `conflict_cells`  out  81  per-cell duplicate mask (see Configuration)

## Operation
- **Cell values**
  - 0: empty.
  - 1..9: digit.
  - 10..15: illegal. Treated as empty for duplicate checks and as not filled for the win check.
- **Units**
  - u = 0..8: row u.
  - u = 9..17: column u-9.
  - u = 18..26: box b = u-18, rows 3*(b/3)..+2, cols 3*(b%3)..+2.
- **State** `snap` holds a 324-bit copy of the board under check. The FSM has states IDLE, SCAN, DONE and a 5-bit unit counter `u`.
- **IDLE**
  - If `init_tag` is high and `cur_map != snap`: load `snap <= cur_map`, clear the scratch accumulators, set `u = 0`, go to SCAN.
- **SCAN** (one unit per cycle, on `snap`)
  - `dup_acc |=` (any digit 1..9 appears two or more times in unit u).
  - For u < 9: `full_acc &=` (all 9 cells hold 1..9).
  - `cells_acc |=` the cells of unit u whose digit appears two or more times in unit u.
  - If u == 26, go to DONE; otherwise u++.
- **DONE** (one cycle)
  - `conflict <= dup_acc`.
  - `win_tag <= full_acc & ~dup_acc`.
  - `conflict_cells <= cells_acc`.
  - Pulse `done`, return to IDLE.
- **Board changes mid-scan:** if `cur_map != snap` in SCAN or DONE, abort. Reload `snap`, clear the accumulators, restart at u = 0. Published outputs hold their previous values and no `done` pulse is issued for the aborted scan.
- **`init_tag` low in any state**
  - Next state IDLE; `snap <= 0`.
  - `win_tag`, `conflict`, `conflict_cells` cleared to 0; no `done` pulse.
- **An all-zero board** after reset or after `init_tag` falls matches `snap`, so no scan runs and the results stay 0.

## Timing
- **Reset values:** `win_tag=0`, `conflict=0`, `busy=0`, `done=0`, `conflict_cells=0`, `snap=0`, state IDLE, `u=0`.
- **Change detection:** a change that appears at edge t is detected in cycle t.
  - SCAN u=0 runs in cycle t+1, u=26 in cycle t+27.
  - DONE runs in cycle t+28: `done` is high during that cycle and the outputs are updated at its end, visible from cycle t+29.
- **`busy`** is high from cycle t+1 through t+28 inclusive (SCAN and DONE).
- **Back-to-back changes:** the count restarts from the last change. `done` occurs exactly 28 cycles after the final change.
- **Precedence:** `RST_n` over `init_tag` over the change/abort rule.
- **Results are stable:** outputs change only in DONE, on `init_tag` low, or on reset.

## Configuration
- `SUDOKU_CHECKER_CONFLICT_CELLS_EN` defined: the `cells_acc` logic is built and `conflict_cells` reports duplicate cells as described above.
- Not defined: `cells_acc` is not built and `conflict_cells` is tied to 81'b0. `win_tag`, `conflict`, `busy`, `done` and timing are unchanged.

## Test plan
All scenarios use the solved grid G, defined as cell(r,c) = ((3r + r/3 + c) mod 9) + 1.
- **Solved board:** reset, `init_tag=1`, drive G → `busy` high for 28 cycles, then `done`=1 for one cycle. Afterwards `win_tag=1`, `conflict=0`, `conflict_cells=0`.
- **Incomplete board:** G with cell 40 set to 0 → `win_tag=0`, `conflict=0`. Same result with cell 40 set to 4'hC.
- **Row duplicate:** empty board except cells 0 and 1 both 5 → `conflict=1`, `win_tag=0`. With the macro, `conflict_cells` has only bits 0 and 1 set; without it, all zero.
- **Change mid-scan:** drive G, then flip cell 80 to 0 while u=10 → a single `done` pulse, 28 cycles after the flip. `win_tag=0`; the previous outputs hold until that pulse.
- **Disable and reset mid-scan:** drop `init_tag` mid-scan → idle the next cycle, outputs 0, no `done`. Re-raise it with G held → a full scan runs and gives `win_tag=1`. Assert `RST_n=0` mid-scan → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sudoku_checker.sv
// sudoku_checker: rescans the published 9x9 board one unit (row, column or box)
// per clock whenever it changes, and reports completion/legality and duplicates.
// Optional build macro: SUDOKU_CHECKER_CONFLICT_CELLS_EN enables the per-cell
// duplicate mask on conflict_cells; otherwise conflict_cells is tied to zero.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | snapshot matches the board, results published, waiting
//   S_SCAN  | checking unit u_q (0..8 rows, 9..17 cols, 18..26 boxes)
//   S_DONE  | publishing accumulated results, pulsing done
module sudoku_checker (
  input  logic         CLK_100MHz,
  input  logic         RST_n,
  input  logic         init_tag,
  input  logic [323:0] cur_map,
  output logic         win_tag,
  output logic         conflict,
  output logic         busy,
  output logic         done,
  output logic [80:0]  conflict_cells
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [4:0]     u_q, u_d;
  logic [323:0]   snap_q, snap_d;
  logic           dup_acc_q, dup_acc_d;
  logic           full_acc_q, full_acc_d;
  logic           win_q, win_d;
  logic           conflict_q, conflict_d;

  logic [6:0]     cell_idx [9];
  logic [3:0]     cell_val [9];
  logic [8:0]     cell_dup;
  logic           unit_dup;
  logic           unit_full;
  logic           changed;

  assign changed = (cur_map != snap_q);

  // Map the current unit number to its nine board cell indices and values.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      if (u_q < 5'd9)
        cell_idx[k] = 7'(int'(u_q) * 9 + k);
      else if (u_q < 5'd18)
        cell_idx[k] = 7'(k * 9 + int'(u_q) - 9);
      else
        cell_idx[k] = 7'((3 * ((int'(u_q) - 18) / 3) + k / 3) * 9
                         + 3 * ((int'(u_q) - 18) % 3) + k % 3);
      cell_val[k] = snap_q[4 * int'(cell_idx[k]) +: 4];
    end
  end

  // Pairwise duplicate detection within the unit; values 10..15 count as empty.
  always_comb begin
    unit_full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cell_dup[k] = 1'b0;
      if (cell_val[k] == 4'd0 || cell_val[k] > 4'd9) begin
        unit_full = 1'b0;
      end else begin
        for (int j = 0; j < 9; j++) begin
          if (j != k && cell_val[j] == cell_val[k]) cell_dup[k] = 1'b1;
        end
      end
    end
    unit_dup = |cell_dup;
  end

  // Next-state logic: init_tag low wins, then any board change restarts the scan.
  always_comb begin
    state_d    = state_q;
    u_d        = u_q;
    snap_d     = snap_q;
    dup_acc_d  = dup_acc_q;
    full_acc_d = full_acc_q;
    win_d      = win_q;
    conflict_d = conflict_q;
    if (!init_tag) begin
      state_d    = S_IDLE;
      u_d        = 5'd0;
      snap_d     = '0;
      win_d      = 1'b0;
      conflict_d = 1'b0;
    end else if (changed) begin
      state_d    = S_SCAN;
      u_d        = 5'd0;
      snap_d     = cur_map;
      dup_acc_d  = 1'b0;
      full_acc_d = 1'b1;
    end else begin
      case (state_q)
        S_SCAN: begin
          dup_acc_d = dup_acc_q | unit_dup;
          // Rows alone cover every cell, so fullness is only gathered there.
          if (u_q < 5'd9) full_acc_d = full_acc_q & unit_full;
          if (u_q == 5'd26) state_d = S_DONE;
          else              u_d     = u_q + 5'd1;
        end
        S_DONE: begin
          conflict_d = dup_acc_q;
          win_d      = full_acc_q & ~dup_acc_q;
          state_d    = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      u_q        <= 5'd0;
      snap_q     <= '0;
      dup_acc_q  <= 1'b0;
      full_acc_q <= 1'b0;
      win_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      snap_q     <= snap_d;
      dup_acc_q  <= dup_acc_d;
      full_acc_q <= full_acc_d;
      win_q      <= win_d;
      conflict_q <= conflict_d;
    end
  end

  assign win_tag  = win_q;
  assign conflict = conflict_q;
  assign busy     = (state_q != S_IDLE);
  // done is suppressed in the same cycle a change or disable aborts the publish.
  assign done     = init_tag & ~changed & (state_q == S_DONE);

`ifdef SUDOKU_CHECKER_CONFLICT_CELLS_EN
  logic [80:0] cells_unit;
  logic [80:0] cells_acc_q, cells_acc_d;
  logic [80:0] cells_q, cells_d;

  // Scatter this unit's duplicate flags back onto board cell positions.
  always_comb begin
    cells_unit = '0;
    for (int k = 0; k < 9; k++) begin
      if (cell_dup[k]) cells_unit[cell_idx[k]] = 1'b1;
    end
  end

  // Per-cell accumulator follows the same abort/disable priority as the FSM.
  always_comb begin
    cells_acc_d = cells_acc_q;
    cells_d     = cells_q;
    if (!init_tag)                cells_d     = '0;
    else if (changed)             cells_acc_d = '0;
    else if (state_q == S_SCAN)   cells_acc_d = cells_acc_q | cells_unit;
    else if (state_q == S_DONE)   cells_d     = cells_acc_q;
  end

  // Per-cell mask registers.
  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      cells_acc_q <= '0;
      cells_q     <= '0;
    end else begin
      cells_acc_q <= cells_acc_d;
      cells_q     <= cells_d;
    end
  end

  assign conflict_cells = cells_q;
`else
  assign conflict_cells = 81'b0;
`endif

endmodule
